kgp_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the KGP-RISC core. It drives the control inputs of the existing single-datapath block (register-file write select, ALU source/operation, memory write, branch/jump selects) and the PC write enable. It consumes the 32-bit instruction word returned by the instruction ROM. It sequences each instruction through FETCH/DECODE/EXEC/(MEM)/WB so that ROM, data memory and register file all run off one clock.

---
 rtl/kgp_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_kgp_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_ctrl_fsm.sv
// kgp_ctrl_fsm: multi-cycle control unit for the KGP-RISC core.
// Sequences FETCH/DECODE/EXEC/(MEM)/WB and drives the datapath controls.
//
// Ports:
//   Clk, rst (sync, active-high), step_en (sampled in FETCH only)
//   currInstr[31:0]  instruction word, captured on the DECODE->EXEC edge
//   MemtoReg, writeRs, A_0, B_0, write31, chkCarry, CarVal, jump, branch
//                    level controls, held through EXEC/MEM/WB
//   ALU_src[1:0], ALU_control[6:0] = {Op[2:0], B_inv, Cin, BranchType[1:0]}
//   RegWrite, MemWrite, pc_we, carry_we  one-cycle strobes
//   halted, illegal  status; state[2:0] current FSM state
module kgp_ctrl_fsm #(
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [31:0] currInstr,
    output logic        MemtoReg,
    output logic        writeRs,
    output logic        A_0,
    output logic        B_0,
    output logic        write31,
    output logic        chkCarry,
    output logic        CarVal,
    output logic        jump,
    output logic        branch,
    output logic [1:0]  ALU_src,
    output logic [6:0]  ALU_control,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        pc_we,
    output logic        carry_we,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;

    // Decoded instruction: level controls plus per-instruction strobe enables.
    typedef struct packed {
        logic       mem_to_reg;
        logic       write_rs;
        logic       a_0;
        logic       b_0;
        logic       write_31;
        logic       chk_carry;
        logic       car_val;
        logic       jump;
        logic       branch;
        logic [1:0] alu_src;
        logic [6:0] alu_ctrl;
        logic       reg_wr;
        logic       carry_wr;
        logic       mem_op;
        logic       store;
        logic       illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, dec;

    logic [5:0] opcode;
    logic [3:0] funct;
    logic       unused_bits;

    assign opcode      = currInstr[31:26];
    assign funct       = currInstr[3:0];
    assign unused_bits = ^currInstr[25:4];

    // Instruction decoder (only consumed while in DECODE).
    always_comb begin
        dec = '0;
        if (opcode != HALT_OP) begin
            case (opcode)
                6'h00: begin
                    dec.reg_wr  = 1'b1;
                    dec.alu_src = funct[3] ? 2'd2 : 2'd0;
                    case (funct[2:0])
                        3'd0: begin
                            dec.alu_ctrl = {OP_ADD, 4'b0000};
                            dec.carry_wr = 1'b1;
                        end
                        3'd1: begin
                            // comp: 0 - rt via A forced to 0, B inverted, Cin=1
                            dec.a_0      = 1'b1;
                            dec.alu_ctrl = {OP_ADD, 4'b1100};
                            dec.carry_wr = 1'b1;
                        end
                        3'd2: dec.alu_ctrl = {OP_AND, 4'b0000};
                        3'd3: dec.alu_ctrl = {OP_XOR, 4'b0000};
                        3'd4: dec.alu_ctrl = {OP_SLL, 4'b0000};
                        3'd5: dec.alu_ctrl = {OP_SRL, 4'b0000};
                        3'd6: dec.alu_ctrl = {OP_SRA, 4'b0000};
                        default: begin
                            dec         = '0;
                            dec.illegal = 1'b1;
                        end
                    endcase
                end
                6'h01, 6'h02: begin
                    dec.alu_src  = 2'd1;
                    dec.reg_wr   = 1'b1;
                    dec.carry_wr = 1'b1;
                    if (opcode[1]) begin
                        dec.a_0      = 1'b1;
                        dec.alu_ctrl = {OP_ADD, 4'b1100};
                    end
                end
                6'h03: begin
                    dec.alu_src    = 2'd1;
                    dec.write_rs   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.mem_op     = 1'b1;
                    dec.reg_wr     = 1'b1;
                end
                6'h04: begin
                    dec.alu_src = 2'd1;
                    dec.mem_op  = 1'b1;
                    dec.store   = 1'b1;
                end
                6'h05: begin
                    dec.jump   = 1'b1;
                    dec.branch = 1'b1;
                end
                6'h06, 6'h07, 6'h08: begin
                    dec.branch        = 1'b1;
                    dec.b_0           = 1'b1;
                    dec.alu_ctrl[1:0] = opcode[1:0] - 2'd2;
                end
                6'h09: dec.jump = 1'b1;
                6'h0A: begin
                    dec.jump     = 1'b1;
                    dec.write_31 = 1'b1;
                    dec.reg_wr   = 1'b1;
                end
                6'h0B, 6'h0C: begin
                    dec.jump      = 1'b1;
                    dec.chk_carry = 1'b1;
                    dec.car_val   = ~opcode[2];
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // State and captured-control registers.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctrl_d = (state_q == S_DECODE) ? dec : ctrl_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = step_en ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (opcode == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = ctrl_q.mem_op ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic: levels only while an instruction is executing.
    always_comb begin
        MemtoReg    = 1'b0;
        writeRs     = 1'b0;
        A_0         = 1'b0;
        B_0         = 1'b0;
        write31     = 1'b0;
        chkCarry    = 1'b0;
        CarVal      = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        ALU_src     = 2'd0;
        ALU_control = 7'd0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        pc_we       = 1'b0;
        carry_we    = 1'b0;
        halted      = (state_q == S_HALT);
        illegal     = (state_q == S_EXEC) && ctrl_q.illegal;
        state       = state_q;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            MemtoReg    = ctrl_q.mem_to_reg;
            writeRs     = ctrl_q.write_rs;
            A_0         = ctrl_q.a_0;
            B_0         = ctrl_q.b_0;
            write31     = ctrl_q.write_31;
            chkCarry    = ctrl_q.chk_carry;
            CarVal      = ctrl_q.car_val;
            jump        = ctrl_q.jump;
            branch      = ctrl_q.branch;
            ALU_src     = ctrl_q.alu_src;
            ALU_control = ctrl_q.alu_ctrl;
        end
        if (state_q == S_MEM) begin
            MemWrite = ctrl_q.store;
        end
        if (state_q == S_WB) begin
            RegWrite = ctrl_q.reg_wr;
            carry_we = ctrl_q.carry_wr;
            pc_we    = 1'b1;
        end
    end

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Scoreboard bench for kgp_ctrl_fsm: expected per-cycle outputs are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_kgp_ctrl_fsm;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_en = 1'b0;
    logic [31:0] currInstr = '0;
    logic        MemtoReg, writeRs, A_0, B_0, write31, chkCarry, CarVal;
    logic        jump, branch, RegWrite, MemWrite, pc_we, carry_we;
    logic        halted, illegal;
    logic [1:0]  ALU_src;
    logic [6:0]  ALU_control;
    logic [2:0]  state;

    kgp_ctrl_fsm dut (
        .Clk(Clk), .rst(rst), .step_en(step_en), .currInstr(currInstr),
        .MemtoReg(MemtoReg), .writeRs(writeRs), .A_0(A_0), .B_0(B_0),
        .write31(write31), .chkCarry(chkCarry), .CarVal(CarVal),
        .jump(jump), .branch(branch), .ALU_src(ALU_src),
        .ALU_control(ALU_control), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .pc_we(pc_we), .carry_we(carry_we),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       m2r, wrs, a0, b0, w31, chk, cv, jmp, br;
        logic [1:0] src;
        logic [2:0] op;
        logic       binv, cin;
        logic [1:0] bt;
        logic       rw, cw, mem, st, ill, hlt;
    } mdl_t;

    typedef struct packed {
        logic [26:0] v;
        logic [31:0] ins;
        logic [3:0]  ph;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference: what each opcode means, straight from the instruction table.
    function automatic mdl_t model(input logic [31:0] ins);
        mdl_t m;
        int   op;
        int   f;
        m  = '0;
        op = int'(ins[31:26]);
        f  = int'(ins[2:0]);
        if (op == 63) m.hlt = 1'b1;
        else if (op == 0) begin
            if (f == 7) m.ill = 1'b1;
            else begin
                m.rw  = 1'b1;
                m.cw  = (f < 2);
                m.src = ins[3] ? 2'd2 : 2'd0;
                m.op  = (f < 2) ? 3'd0 : 3'(f - 1);
                if (f == 1) begin
                    m.a0 = 1'b1; m.binv = 1'b1; m.cin = 1'b1;
                end
            end
        end else if (op == 1 || op == 2) begin
            m.src = 2'd1; m.rw = 1'b1; m.cw = 1'b1;
            if (op == 2) begin
                m.a0 = 1'b1; m.binv = 1'b1; m.cin = 1'b1;
            end
        end else if (op == 3) begin
            m.src = 2'd1; m.wrs = 1'b1; m.m2r = 1'b1;
            m.mem = 1'b1; m.rw = 1'b1;
        end else if (op == 4) begin
            m.src = 2'd1; m.mem = 1'b1; m.st = 1'b1;
        end else if (op == 5) begin
            m.jmp = 1'b1; m.br = 1'b1;
        end else if (op >= 6 && op <= 8) begin
            m.br = 1'b1; m.b0 = 1'b1; m.bt = 2'(op - 6);
        end else if (op >= 9 && op <= 12) begin
            m.jmp = 1'b1;
            m.w31 = (op == 10);
            m.rw  = (op == 10);
            m.chk = (op >= 11);
            m.cv  = (op == 11);
        end else m.ill = 1'b1;
        return m;
    endfunction

    function automatic logic [26:0] mk(
        input logic [2:0] st, input mdl_t m, input bit lv,
        input bit rws, input bit mws, input bit pcs, input bit cws,
        input bit h, input bit il);
        logic [8:0] lvl;
        logic [1:0] src;
        logic [6:0] ac;
        lvl = lv ? {m.m2r, m.wrs, m.a0, m.b0, m.w31,
                    m.chk, m.cv, m.jmp, m.br} : 9'd0;
        src = lv ? m.src : 2'd0;
        ac  = lv ? {m.op, m.binv, m.cin, m.bt} : 7'd0;
        return {st, lvl, src, ac, rws, mws, pcs, cws, h, il};
    endfunction

    // Monitor: one expected record per cycle whenever the queue has one.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            rec_t        e;
            logic [26:0] act;
            e   = exp_q.pop_front();
            act = {state, MemtoReg, writeRs, A_0, B_0, write31, chkCarry,
                   CarVal, jump, branch, ALU_src, ALU_control, RegWrite,
                   MemWrite, pc_we, carry_we, halted, illegal};
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL ins=%h ph%0d: got %h want %h",
                          e.ins, e.ph, act, e.v);
        end
    end

    task automatic push(input logic [26:0] v, input logic [31:0] ins,
                        input int ph);
        rec_t r;
        r.v   = v;
        r.ins = ins;
        r.ph  = 4'(ph);
        exp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        mdl_t z;
        z = '0;
        for (int i = 0; i < n; i++) begin
            step_en = 1'b0;
            push(mk(3'd0, z, 0, 0, 0, 0, 0, 0, 0), 32'hFFFF_FFFF, 15);
            @(posedge Clk); #1;
        end
    endtask

    // Run one instruction from FETCH; rst_at < 0 means no reset,
    // otherwise rst is raised during that cycle index.
    task automatic issue(input logic [31:0] ins, input int rst_at,
                         input int halt_cyc);
        mdl_t        m;
        logic [26:0] recs[$];
        m = model(ins);
        recs.push_back(mk(3'd0, m, 0, 0, 0, 0, 0, 0, 0));
        recs.push_back(mk(3'd1, m, 0, 0, 0, 0, 0, 0, 0));
        if (m.hlt) begin
            for (int i = 0; i < halt_cyc; i++)
                recs.push_back(mk(3'd5, '0, 0, 0, 0, 0, 0, 1, 0));
        end else begin
            recs.push_back(mk(3'd2, m, 1, 0, 0, 0, 0, 0, m.ill));
            if (m.mem)
                recs.push_back(mk(3'd3, m, 1, 0, m.st, 0, 0, 0, 0));
            recs.push_back(mk(3'd4, m, 1, m.rw, 0, 1, m.cw, 0, 0));
        end
        if (rst_at >= 0)
            while (recs.size() > rst_at + 1) void'(recs.pop_back());
        for (int i = 0; i < recs.size(); i++) push(recs[i], ins, i);
        step_en   = 1'b1;
        currInstr = ins;
        for (int c = 0; c < recs.size(); c++) begin
            if (c == rst_at) rst = 1'b1;
            @(posedge Clk); #1;
            rst = 1'b0;
            if (c == 0) step_en = 1'($urandom_range(0, 1));
            if (c == 1) currInstr = $urandom;
        end
    endtask

    function automatic logic [31:0] mkins(input logic [5:0] op,
                                          input logic [3:0] fn);
        logic [31:0] r;
        r       = $urandom;
        r[31:26] = op;
        r[3:0]   = fn;
        return r;
    endfunction

    initial begin
        logic [31:0] r;
        int          ra;
        repeat (2) @(posedge Clk);
        #1 rst = 1'b0;
        idle(2);
        issue(mkins(6'h01, 4'h0), -1, 0);
        issue(mkins(6'h03, 4'h5), -1, 0);
        issue(mkins(6'h04, 4'h2), -1, 0);
        issue(mkins(6'h04, 4'h7), 3, 0);
        issue(mkins(6'h0A, 4'h0), -1, 0);
        issue(mkins(6'h0C, 4'h0), -1, 0);
        issue(mkins(6'h07, 4'h0), -1, 0);
        issue(mkins(6'h20, 4'h0), -1, 0);
        idle(3);
        for (int f = 0; f < 16; f++)
            issue(mkins(6'h00, 4'(f)), -1, 0);
        issue(mkins(6'h02, 4'h0), -1, 0);
        for (int op = 5; op <= 12; op++)
            issue(mkins(6'(op), 4'h0), -1, 0);
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if ($urandom_range(0, 15) <= 12)
                r[31:26] = 6'($urandom_range(0, 12));
            else
                r[31:26] = 6'($urandom_range(13, 62));
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            issue(r, ra, 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        issue(mkins(6'h3F, 4'h0), 13, 12);
        idle(2);
        issue(mkins(6'h01, 4'h0), -1, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
